// File: rtl/stim_sequencer_if.sv
// Bundle between the bench/config master and the stimulus sequencer:
// step-table programming, run control, generator settings and probe window.
interface stim_sequencer_if #(
    parameter int NUM_STEPS = 8,
    parameter int CODE_W    = 8,
    parameter int DWELL_W   = 16
);
    localparam int SW = $clog2(NUM_STEPS);

    logic                        cfg_we;
    logic [SW-1:0]               cfg_addr;
    logic [DWELL_W+4*CODE_W-1:0] cfg_data;
    logic [SW:0]                 num_steps;
    logic                        start;
    logic                        abort;
    logic                        busy;
    logic                        gen_en;
    logic [CODE_W-1:0]           amp_code;
    logic [CODE_W-1:0]           freq_code;
    logic [CODE_W-1:0]           damp_code;
    logic [CODE_W-1:0]           phase_code;
    logic                        cap_en;
    logic [SW-1:0]               step_idx;
    logic                        done;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_steps, start, abort,
        output busy, gen_en, amp_code, freq_code, damp_code, phase_code,
               cap_en, step_idx, done
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_steps, start, abort,
        input  busy, gen_en, amp_code, freq_code, damp_code, phase_code,
               cap_en, step_idx, done
    );
endinterface

// File: rtl/stim_sequencer.sv
// Steps a code-controlled sine/damped-sine generator through a programmed table:
// each step settles, opens a probe capture window for its dwell, then idles a gap.
module stim_sequencer #(
    parameter int NUM_STEPS  = 8,
    parameter int CODE_W     = 8,
    parameter int DWELL_W    = 16,
    parameter int SETTLE_CYC = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    stim_sequencer_if.slave  bus
);
    localparam int SW  = $clog2(NUM_STEPS);
    localparam int SW1 = SW + 1;
    localparam int CSW = 4 * CODE_W;
    localparam int EW  = DWELL_W + CSW;

    localparam logic [DWELL_W-1:0] SETTLE_LOAD = DWELL_W'(SETTLE_CYC - 1);
    localparam logic [DWELL_W-1:0] GAP_LOAD    = DWELL_W'(GAP_CYC - 1);
    localparam logic [DWELL_W-1:0] CNT_ONE     = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] CNT_ZERO    = {DWELL_W{1'b0}};
    localparam logic [SW-1:0]      IDX_ONE     = SW'(1);
    localparam logic [SW-1:0]      IDX_ZERO    = {SW{1'b0}};
    localparam logic [SW-1:0]      LAST_MAX    = SW'(NUM_STEPS - 1);
    localparam logic [SW:0]        STEPS_MAX   = SW1'(NUM_STEPS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_DWELL  = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Dwell counter reload: a zero dwell still gives a one-cycle window.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [EW-1:0] entry);
        logic [DWELL_W-1:0] d;
        d = entry[EW-1:CSW];
        if (d == CNT_ZERO) begin
            dwell_load = CNT_ZERO;
        end else begin
            dwell_load = d - CNT_ONE;
        end
    endfunction

    state_t             state_q, state_d;
    logic [EW-1:0]      table_q [NUM_STEPS];
    logic [EW-1:0]      table_d [NUM_STEPS];
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]      step_q, step_d;
    logic [SW-1:0]      last_q, last_d;
    logic [CSW-1:0]     codes_q, codes_d;
    logic               busy_q, busy_d;
    logic               gen_q, gen_d;
    logic               cap_q, cap_d;
    logic               done_q, done_d;
    logic [SW-1:0]      sel_idx_s;
    logic [EW-1:0]      sel_entry_s;

    // Table port: the current step while settling (for its dwell), the next step otherwise.
    always_comb begin
        if (state_q == S_SETTLE) begin
            sel_idx_s = step_q;
        end else if (state_q == S_GAP) begin
            sel_idx_s = step_q + IDX_ONE;
        end else begin
            sel_idx_s = IDX_ZERO;
        end
        sel_entry_s = table_q[sel_idx_s];
    end

    // Table programming, locked out while a sequence runs.
    always_comb begin
        table_d = table_q;
        if (bus.cfg_we && !busy_q) begin
            table_d[bus.cfg_addr] = bus.cfg_data;
        end else begin
            table_d = table_q;
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        last_d  = last_q;
        codes_d = codes_q;
        busy_d  = busy_q;
        gen_d   = gen_q;
        cap_d   = cap_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    if (bus.num_steps == {SW1{1'b0}}) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        last_d  = (bus.num_steps >= STEPS_MAX) ? LAST_MAX
                                                               : (bus.num_steps[SW-1:0] - IDX_ONE);
                        step_d  = IDX_ZERO;
                        codes_d = sel_entry_s[CSW-1:0];
                        busy_d  = 1'b1;
                        gen_d   = 1'b1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gen_d   = 1'b0;
                    cap_d   = 1'b0;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = S_DWELL;
                    cap_d   = 1'b1;
                    cnt_d   = dwell_load(sel_entry_s);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DWELL: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gen_d   = 1'b0;
                    cap_d   = 1'b0;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = S_GAP;
                    gen_d   = 1'b0;
                    cap_d   = 1'b0;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gen_d   = 1'b0;
                    cap_d   = 1'b0;
                end else if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (step_q == last_q) begin
                    state_d = S_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    step_d  = step_q + IDX_ONE;
                    codes_d = sel_entry_s[CSW-1:0];
                    gen_d   = 1'b1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                gen_d   = 1'b0;
                cap_d   = 1'b0;
            end
        endcase
    end

    // State, table and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            table_q <= '{default: {EW{1'b0}}};
            cnt_q   <= CNT_ZERO;
            step_q  <= IDX_ZERO;
            last_q  <= IDX_ZERO;
            codes_q <= {CSW{1'b0}};
            busy_q  <= 1'b0;
            gen_q   <= 1'b0;
            cap_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            table_q <= table_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            last_q  <= last_d;
            codes_q <= codes_d;
            busy_q  <= busy_d;
            gen_q   <= gen_d;
            cap_q   <= cap_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.gen_en     = gen_q;
    assign bus.cap_en     = cap_q;
    assign bus.done       = done_q;
    assign bus.step_idx   = step_q;
    assign bus.amp_code   = codes_q[CODE_W-1:0];
    assign bus.freq_code  = codes_q[2*CODE_W-1:CODE_W];
    assign bus.damp_code  = codes_q[3*CODE_W-1:2*CODE_W];
    assign bus.phase_code = codes_q[4*CODE_W-1:3*CODE_W];
endmodule
